tdm_slot_sequencer: RTL and testbench
=====================================

Name: tdm_slot_sequencer

Overview:
- Upstream feeder for the 1-to-16 demux in the wireless receive path.
- Takes a serial TDM bitstream with a frame-sync marker and tracks the slot and bit position within each frame.
- Drives the demux's 4-bit slot select and data bit with a registered, qualified valid.
- Provides sync hunting, flywheel (missed-sync tolerance), re-alignment and error flags.

Parameters:
- BITS_PER_SLOT, 1, serial bits carried per slot before select advances (1..16).
- MAX_MISS, 3, consecutive missing frame-syncs tolerated in FLYWHEEL before dropping to HUNT (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial TDM data bit.
- bit_valid  in  1  bit_in is valid this cycle. A cycle with bit_valid=0 is ignored entirely.
- frame_sync  in  1  qualified by bit_valid; marks this bit as slot 0, bit 0.
- select_4  out  4  slot index to demux select.
- tdm_data_out  out  1  data bit to demux data input.
- tdm_data_valid  out  1  select_4/tdm_data_out carry a valid slot bit.
- locked  out  1  state is LOCKED or FLYWHEEL.
- frame_err  out  1  one-cycle pulse: sync seen at an unexpected position.
- lock_lost  out  1  one-cycle pulse: FLYWHEEL exhausted, back to HUNT.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - all outputs go to 0; counters go to 0; state goes to HUNT; miss_cnt goes to 0.
  - Reset mid-frame discards the partial frame.
- Position counters:
  - bit_cnt: 0..BITS_PER_SLOT-1.
  - slot_cnt: 0..15.
  - Both advance only on accepted bits (bit_valid=1 and state != HUNT).
  - bit_cnt wraps to 0 and increments slot_cnt; slot_cnt wraps 15 to 0.
  - The "expected sync position" is (slot_cnt=0, bit_cnt=0) after a wrap.
- Latency: an accepted bit in cycle N appears in cycle N+1 as:
  - tdm_data_out = that bit;
  - select_4 = the slot it belongs to;
  - tdm_data_valid = 1.
  - With no accepted bit, tdm_data_valid=0; select_4 and tdm_data_out hold their last values.
- States:
  - HUNT:
    - tdm_data_valid stays 0; bits without frame_sync are dropped.
    - bit_valid and frame_sync: go to LOCKED, output the bit as slot 0. The next position is bit 1 (or slot 1 if BITS_PER_SLOT=1).
  - LOCKED:
    - Bit at the expected position with frame_sync: normal.
    - Bit at the expected position without frame_sync: go to FLYWHEEL with miss_cnt=1. The bit is still output as slot 0.
    - frame_sync at any other position: frame_err pulse; re-align (the bit is treated as slot 0 bit 0 and output as slot 0); stay LOCKED.
  - FLYWHEEL:
    - Free-runs and outputs exactly like LOCKED.
    - Sync at the expected position: go to LOCKED, miss_cnt=0.
    - No sync at the expected position: miss_cnt++.
    - If miss_cnt would reach MAX_MISS+1: lock_lost pulse, go to HUNT, the bit is dropped (tdm_data_valid=0), counters cleared.
    - Misplaced sync: frame_err pulse, re-align, go to LOCKED, miss_cnt=0.
- Flag timing: frame_err and lock_lost are registered and assert in the same cycle as the affected bit's output slot (N+1).
- frame_sync with bit_valid=0 is ignored.

Optional Feature:
- Macro: SLOT_MASK_EN.
- When defined:
  - adds input slot_mask [15:0];
  - a bit whose slot has slot_mask[slot]=0 produces tdm_data_valid=0 and tdm_data_out=0;
  - counters and sync tracking are unaffected;
  - slot_mask is sampled in the cycle the bit is accepted.
- When undefined: the port is absent and all slots are valid.

Decomposition:
- Package tdm_pkg:
  - NUM_SLOTS=16, SLOT_W=4;
  - state enum {HUNT, LOCKED, FLYWHEEL};
  - miss counter width (4).
- Sub-module tdm_pos_counter:
  - holds bit_cnt/slot_cnt with advance, realign and clear inputs;
  - outputs slot index and at_expected_sync.
- The FSM, flags and output registers stay in the top module.

Test Plan:
- Clean lock (BITS_PER_SLOT=1):
  - Stimulus: after rst, 40 idle bits, then bits with sync every 16; slot 9 data=1, others 0.
  - Response: no valid during hunt; first valid has select_4=0 one cycle after the sync bit; select_4=9 with data 1; locked=1.
- Misplaced sync:
  - Stimulus: while locked, assert frame_sync on slot 5.
  - Response: frame_err pulses once; that bit is output with select_4=0; following bits count 1,2,…
- Flywheel recovery:
  - Stimulus: drop 2 syncs (MAX_MISS=3), then restore sync.
  - Response: locked stays 1; select continues wrapping 15 to 0; no lock_lost.
- Lock loss:
  - Stimulus: drop 4 syncs.
  - Response: lock_lost pulses at the 4th expected position; locked=0; tdm_data_valid=0 until the next sync.
- Gapped input and BITS_PER_SLOT=4:
  - Stimulus: random bit_valid=0 gaps.
  - Response: select_4 advances every 4 accepted bits; gaps produce tdm_data_valid=0.
- Reset mid-frame and mask:
  - Stimulus: rst at slot 7.
  - Response: all outputs 0 next cycle, state HUNT.
  - With SLOT_MASK_EN and slot_mask=16'hFFF7: slot 3 never shows valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and FSM state encoding for the TDM slot sequencer.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned BIT_W     = 4;
  localparam int unsigned MISS_W    = 4;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    LOCKED   = 2'd1,
    FLYWHEEL = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_pos_counter.sv
// Bit/slot position tracker within a TDM frame; holds the position of the next bit to arrive.
module tdm_pos_counter
  import tdm_pkg::*;
#(
  parameter int unsigned BITS_PER_SLOT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              realign,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot,
  output logic              at_expected_sync
);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BITS_PER_SLOT - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  logic [BIT_W-1:0]  bit_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [BIT_W-1:0]  base_bit;
  logic [SLOT_W-1:0] base_slot;

  // A realigned bit is consumed as slot 0 bit 0, so stepping starts from the origin.
  always_comb begin
    base_bit  = bit_cnt;
    base_slot = slot_cnt;
    if (realign) begin
      base_bit  = '0;
      base_slot = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_cnt  <= '0;
      slot_cnt <= '0;
    end else if (advance || realign) begin
      if (base_bit == LAST_BIT) begin
        bit_cnt  <= '0;
        slot_cnt <= (base_slot == LAST_SLOT) ? '0 : base_slot + SLOT_W'(1);
      end else begin
        bit_cnt  <= base_bit + BIT_W'(1);
        slot_cnt <= base_slot;
      end
    end
  end

  assign slot             = slot_cnt;
  assign at_expected_sync = (slot_cnt == '0) && (bit_cnt == '0);

endmodule

// File: rtl/tdm_slot_sequencer.sv
// Frame-sync tracking front end for the 1-to-16 receive demux.
// Optional SLOT_MASK_EN adds a per-slot output mask.
module tdm_slot_sequencer
  import tdm_pkg::*;
#(
  parameter int unsigned BITS_PER_SLOT = 1,
  parameter int unsigned MAX_MISS      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 frame_sync,
`ifdef SLOT_MASK_EN
  input  logic [NUM_SLOTS-1:0] slot_mask,
`endif
  output logic [SLOT_W-1:0]    select_4,
  output logic                 tdm_data_out,
  output logic                 tdm_data_valid,
  output logic                 locked,
  output logic                 frame_err,
  output logic                 lock_lost
);

  state_t            state;
  logic [MISS_W-1:0] miss_cnt;
  logic [SLOT_W-1:0] cur_slot;
  logic              at_exp;

  logic              hunting_c;
  logic              realign_c;
  logic              exhaust_c;
  logic              advance_c;
  logic              emit_c;
  logic [SLOT_W-1:0] emit_slot_c;
  logic              keep_c;

  // Per-bit decision shared by the position counter and the output registers.
  assign hunting_c   = (state == HUNT);
  assign realign_c   = bit_valid && frame_sync && (hunting_c || !at_exp);
  assign exhaust_c   = bit_valid && (state == FLYWHEEL) && at_exp && !frame_sync
                       && (miss_cnt == MISS_W'(MAX_MISS));
  assign advance_c   = bit_valid && !hunting_c && !realign_c && !exhaust_c;
  assign emit_c      = advance_c || realign_c;
  assign emit_slot_c = realign_c ? '0 : cur_slot;

`ifdef SLOT_MASK_EN
  assign keep_c = slot_mask[emit_slot_c];
`else
  assign keep_c = 1'b1;
`endif

  tdm_pos_counter #(
    .BITS_PER_SLOT (BITS_PER_SLOT)
  ) u_pos (
    .clk              (clk),
    .rst              (rst),
    .advance          (advance_c),
    .realign          (realign_c),
    .clear            (exhaust_c),
    .slot             (cur_slot),
    .at_expected_sync (at_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      miss_cnt       <= '0;
      select_4       <= '0;
      tdm_data_out   <= 1'b0;
      tdm_data_valid <= 1'b0;
      locked         <= 1'b0;
      frame_err      <= 1'b0;
      lock_lost      <= 1'b0;
    end else begin
      tdm_data_valid <= 1'b0;
      frame_err      <= 1'b0;
      lock_lost      <= 1'b0;

      if (emit_c) begin
        select_4       <= emit_slot_c;
        tdm_data_out   <= bit_in & keep_c;
        tdm_data_valid <= keep_c;
      end

      if (bit_valid) begin
        unique case (state)
          HUNT: begin
            if (frame_sync) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end
          end
          LOCKED: begin
            if (frame_sync && !at_exp) begin
              frame_err <= 1'b1;
            end else if (at_exp && !frame_sync) begin
              state    <= FLYWHEEL;
              miss_cnt <= MISS_W'(1);
            end
          end
          FLYWHEEL: begin
            if (frame_sync) begin
              state     <= LOCKED;
              miss_cnt  <= '0;
              frame_err <= !at_exp;
            end else if (exhaust_c) begin
              state     <= HUNT;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              miss_cnt  <= '0;
            end else if (at_exp) begin
              miss_cnt <= miss_cnt + MISS_W'(1);
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Self-checking bench: two sequencers (1 and 4 bits per slot) against a frame-position model.
module tb_tdm_slot_sequencer;

  localparam int MAXM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r1, v1, b1, s1;
  logic        r4, v4, b4, s4;
  logic [3:0]  sel1, sel4;
  logic        dat1, vld1, lk1, fe1, ll1;
  logic        dat4, vld4, lk4, fe4, ll4;
  logic [15:0] mask1, mask4;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  tdm_slot_sequencer #(.BITS_PER_SLOT(1), .MAX_MISS(MAXM)) dut1 (
    .clk(clk), .rst(r1), .bit_in(b1), .bit_valid(v1), .frame_sync(s1),
`ifdef SLOT_MASK_EN
    .slot_mask(mask1),
`endif
    .select_4(sel1), .tdm_data_out(dat1), .tdm_data_valid(vld1),
    .locked(lk1), .frame_err(fe1), .lock_lost(ll1)
  );

  tdm_slot_sequencer #(.BITS_PER_SLOT(4), .MAX_MISS(MAXM)) dut4 (
    .clk(clk), .rst(r4), .bit_in(b4), .bit_valid(v4), .frame_sync(s4),
`ifdef SLOT_MASK_EN
    .slot_mask(mask4),
`endif
    .select_4(sel4), .tdm_data_out(dat4), .tdm_data_valid(vld4),
    .locked(lk4), .frame_err(fe4), .lock_lost(ll4)
  );

  // Model: frame position as a single integer 0..16*bps-1; st 0=hunt 1=locked 2=flywheel.
  typedef struct {
    int         st;
    int         pos;
    int         miss;
    logic [3:0] sel;
    logic       dat, vld, lck, ferr, llost;
  } mdl_t;

  mdl_t m1, m4;

  function automatic mdl_t step(input mdl_t m, input int bps, input logic rst,
                                input logic v, input logic b, input logic s,
                                input logic [15:0] mask);
    mdl_t n = m;
    bit   emit = 1'b0;
    int   slot;
    if (rst) begin
      n.st = 0; n.pos = 0; n.miss = 0;
      n.sel = 4'd0; n.dat = 1'b0; n.vld = 1'b0;
      n.lck = 1'b0; n.ferr = 1'b0; n.llost = 1'b0;
      return n;
    end
    n.vld = 1'b0; n.ferr = 1'b0; n.llost = 1'b0;
    if (v) begin
      if (n.st == 0) begin
        if (s) begin n.st = 1; n.pos = 0; n.miss = 0; emit = 1'b1; end
      end else if (s && n.pos != 0) begin
        n.ferr = 1'b1; n.st = 1; n.miss = 0; n.pos = 0; emit = 1'b1;
      end else if (s) begin
        n.st = 1; n.miss = 0; emit = 1'b1;
      end else if (n.pos == 0) begin
        if (n.st == 1) begin
          n.st = 2; n.miss = 1; emit = 1'b1;
        end else if (n.miss == MAXM) begin
          n.llost = 1'b1; n.st = 0; n.miss = 0; n.pos = 0;
        end else begin
          n.miss++; emit = 1'b1;
        end
      end else begin
        emit = 1'b1;
      end
      if (emit) begin
        slot  = n.pos / bps;
        n.sel = 4'(slot);
        n.dat = b & mask[slot];
        n.vld = mask[slot];
        n.pos = (n.pos + 1) % (16 * bps);
      end
    end
    n.lck = (n.st != 0);
    return n;
  endfunction

  always @(posedge clk) begin
    m1 = step(m1, 1, r1, v1, b1, s1, mask1);
    m4 = step(m4, 4, r4, v4, b4, s4, mask4);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d1.select_4", sel1, m1.sel);
      chk("d1.data", dat1, m1.dat);
      chk("d1.valid", vld1, m1.vld);
      chk("d1.locked", lk1, m1.lck);
      chk("d1.frame_err", fe1, m1.ferr);
      chk("d1.lock_lost", ll1, m1.llost);
      chk("d4.select_4", sel4, m4.sel);
      chk("d4.data", dat4, m4.dat);
      chk("d4.valid", vld4, m4.vld);
      chk("d4.locked", lk4, m4.lck);
      chk("d4.frame_err", fe4, m4.ferr);
      chk("d4.lock_lost", ll4, m4.llost);
    end
  end

  task automatic t1(input logic v, input logic b, input logic s);
    v1 = v; b1 = b; s1 = s;
    @(negedge clk);
  endtask

  task automatic t4(input logic v, input logic b, input logic s);
    v4 = v; b4 = b; s4 = s;
    @(negedge clk);
  endtask

  initial begin
    mask1 = 16'hFFFF;
    mask4 = 16'hFFFF;
`ifdef SLOT_MASK_EN
    mask1 = 16'hFFF7;
`endif
    r1 = 1'b1; v1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
    r4 = 1'b1; v4 = 1'b0; b4 = 1'b0; s4 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset.select_4", sel1, 0);
    chk("reset.valid", vld1, 0);
    chk("reset.locked", lk1, 0);
    chk("reset.d4_locked", lk4, 0);
    r1 = 1'b0;
    r4 = 1'b0;

    // Hunting: unsynced bits are dropped.
    for (int i = 0; i < 40; i++) t1(1'b1, (i % 3) == 0, 1'b0);
    chk("hunt.valid", vld1, 0);
    chk("hunt.locked", lk1, 0);

    // Clean lock, slot 9 carries a 1; one gated-off sync must be ignored.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        if (f == 1 && i == 4) begin
          t1(1'b0, 1'b0, 1'b1);
          chk("gap.valid", vld1, 0);
        end
        t1(1'b1, i == 9, i == 0);
        if (f == 0 && i == 0) begin
          chk("lock.first_sel", sel1, 0);
          chk("lock.first_valid", vld1, 1);
          chk("lock.locked", lk1, 1);
        end
        if (i == 9) begin
          chk("lock.slot9_sel", sel1, 9);
          chk("lock.slot9_data", dat1, 1);
        end
      end
    end

    // Misplaced sync at slot 5 re-aligns the frame.
    for (int i = 0; i < 6; i++) t1(1'b1, 1'b0, i == 0 || i == 5);
    chk("misplaced.frame_err", fe1, 1);
    chk("misplaced.sel", sel1, 0);
    for (int i = 1; i < 16; i++) begin
      t1(1'b1, i == 9, 1'b0);
      if (i == 1) begin
        chk("misplaced.next_sel", sel1, 1);
        chk("misplaced.err_cleared", fe1, 0);
      end
    end
    for (int i = 0; i < 16; i++) t1(1'b1, i == 9, i == 0);

    // Flywheel: two missing syncs then recovery.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin
        t1(1'b1, i == 9, i == 0 && f >= 2);
        if (f == 1 && i == 0) begin
          chk("flywheel.locked", lk1, 1);
          chk("flywheel.wrap_sel", sel1, 0);
        end
      end
    end

    // Four missing syncs: lock is lost at the fourth expected position.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin
        t1(1'b1, i == 9, 1'b0);
        if (f == 3 && i == 0) begin
          chk("lostlock.pulse", ll1, 1);
          chk("lostlock.valid", vld1, 0);
          chk("lostlock.locked", lk1, 0);
        end
        if (f == 3 && i == 1) chk("lostlock.one_shot", ll1, 0);
      end
    end

    // Resync, then reset at slot 7.
    for (int i = 0; i < 8; i++) t1(1'b1, i[0], i == 0);
    chk("resync.sel7", sel1, 7);
    r1 = 1'b1;
    t1(1'b1, 1'b1, 1'b0);
    r1 = 1'b0;
    chk("midreset.sel", sel1, 0);
    chk("midreset.data", dat1, 0);
    chk("midreset.valid", vld1, 0);
    chk("midreset.locked", lk1, 0);
    for (int i = 0; i < 10; i++) t1(1'b1, 1'b1, 1'b0);

    // Four bits per slot with random idle gaps.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(2) == 0) t4(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        t4(1'b1, 1'($urandom_range(1)), i == 0);
        if (f == 0 && i == 3)  chk("bps4.sel_bit3", sel4, 0);
        if (f == 0 && i == 4)  chk("bps4.sel_bit4", sel4, 1);
        if (f == 0 && i == 63) chk("bps4.sel_last", sel4, 15);
      end
    end
    for (int i = 0; i < 10; i++) t4(1'b1, 1'b0, i == 0);
    t4(1'b1, 1'b1, 1'b1);
    chk("bps4.misplaced_err", fe4, 1);
    chk("bps4.misplaced_sel", sel4, 0);
    for (int i = 1; i < 70; i++) t4(1'b1, 1'(i), i == 64);
    chk("bps4.locked", lk4, 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
